// File: rtl/bit_serializer.sv
// Purpose : parallel-to-serial front end; WIDTH-bit words in over valid/ready, one bit per clk out on x.
// Latency : word accepted at edge N shows its first bit on x in cycle N..N+1 and its last bit WIDTH-1 cycles later.
// Backpres: din_ready = rst_n & ~hold_full; one holding register behind the shift register keeps frames gap-free.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   din, din_valid    parallel word and its valid
//   din_ready         word can be accepted this cycle (combinational)
//   x, x_valid        registered serial bit and its qualifier
//   frame_start/end   x carries the first / last bit of a word
//   idle              shift and holding registers both empty (registered)
//   word_count        completed words, wraps at 16'hFFFF
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             idle,
  output logic [15:0]      word_count
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] NEXT2LST = CW'(WIDTH - 2);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign din_ready = rst_n & ~hold_full;
  assign accept    = din_valid & din_ready;

  // Bit that goes onto x first for a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift register after one bit has been sent; the outgoing end is always
  // the one first_bit() looks at, so x tracks first_bit(sh).
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sh          <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      idle        <= 1'b1;
      word_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_SHIFT;
            sh          <= din;
            cnt         <= '0;
            x           <= first_bit(din);
            x_valid     <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
            idle        <= 1'b0;
          end else begin
            x           <= 1'b0;
            x_valid     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            idle        <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (cnt == LAST) begin
            // x currently carries the last bit: this edge completes the word.
            word_count <= word_count + 16'd1;
            cnt        <= '0;
            if (hold_full) begin
              sh          <= hold;
              hold_full   <= 1'b0;
              x           <= first_bit(hold);
              x_valid     <= 1'b1;
              frame_start <= 1'b1;
              frame_end   <= 1'b0;
              idle        <= 1'b0;
            end else if (accept) begin
              // Bypass: holding register empty, new word goes straight in.
              sh          <= din;
              x           <= first_bit(din);
              x_valid     <= 1'b1;
              frame_start <= 1'b1;
              frame_end   <= 1'b0;
              idle        <= 1'b0;
            end else begin
              state       <= S_IDLE;
              x           <= 1'b0;
              x_valid     <= 1'b0;
              frame_start <= 1'b0;
              frame_end   <= 1'b0;
              idle        <= 1'b1;
            end
          end else begin
            sh          <= advance(sh);
            cnt         <= cnt + 1'b1;
            x           <= first_bit(advance(sh));
            frame_start <= 1'b0;
            frame_end   <= (cnt == NEXT2LST);
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Purpose : directed bench for bit_serializer; MSB-first and LSB-first instances share one stimulus.
// Latency : model predicts outputs per cycle from a queue of accepted words and a bit position.
// Backpres: model predicts din_ready as "fewer than two words outstanding".
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic        m_ready, m_x, m_xv, m_fs, m_fe, m_idle;
  logic [15:0] m_wc;
  logic        l_ready, l_x, l_xv, l_fs, l_fe, l_idle;
  logic [15:0] l_wc;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .x(m_x), .x_valid(m_xv), .frame_start(m_fs), .frame_end(m_fe), .idle(m_idle),
    .word_count(m_wc)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .x(l_x), .x_valid(l_xv), .frame_start(l_fs), .frame_end(l_fe), .idle(l_idle),
    .word_count(l_wc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q holds every accepted word not yet fully sent; q[0] is on the wire at bit pos.
  logic [W-1:0] q[$];
  int           pos = 0;
  logic [15:0]  mcount = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc;
    chk_en = 1'b1;
    if (!rst_n) begin
      q.delete();
      pos    = 0;
      mcount = '0;
    end else begin
      acc = din_valid && (q.size() < 2);
      if (q.size() > 0) begin
        if (pos == W - 1) begin
          void'(q.pop_front());
          mcount = mcount + 16'd1;
          pos    = 0;
        end else begin
          pos++;
        end
      end
      if (acc) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic       ev, ex_m, ex_l, efs, efe, erdy;
      logic [W-1:0] cur;
      ev   = (q.size() > 0);
      cur  = ev ? q[0] : '0;
      ex_m = ev ? cur[W-1-pos] : 1'b0;
      ex_l = ev ? cur[pos] : 1'b0;
      efs  = ev && (pos == 0);
      efe  = ev && (pos == W - 1);
      erdy = rst_n && (q.size() < 2);
      check("m_din_ready", 32'(m_ready), 32'(erdy));
      check("m_x", 32'(m_x), 32'(ex_m));
      check("m_x_valid", 32'(m_xv), 32'(ev));
      check("m_frame_start", 32'(m_fs), 32'(efs));
      check("m_frame_end", 32'(m_fe), 32'(efe));
      check("m_idle", 32'(m_idle), 32'(!ev));
      check("m_word_count", 32'(m_wc), 32'(mcount));
      check("l_din_ready", 32'(l_ready), 32'(erdy));
      check("l_x", 32'(l_x), 32'(ex_l));
      check("l_x_valid", 32'(l_xv), 32'(ev));
      check("l_frame_start", 32'(l_fs), 32'(efs));
      check("l_frame_end", 32'(l_fe), 32'(efe));
      check("l_idle", 32'(l_idle), 32'(!ev));
      check("l_word_count", 32'(l_wc), 32'(mcount));
    end
  end

  // ---------------- serial capture for literal expectations ----------------
  logic [31:0] cap_m, cap_l;
  int          ncap, run, maxrun;

  always @(negedge clk) begin
    if (m_xv === 1'b1) begin
      cap_m = {cap_m[30:0], m_x};
      ncap++;
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (l_xv === 1'b1) cap_l = {cap_l[30:0], l_x};
  end

  task automatic clear_cap();
    cap_m  = '0;
    cap_l  = '0;
    ncap   = 0;
    run    = 0;
    maxrun = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold din_valid until an edge accepts it.
  task automatic offer(input logic [W-1:0] w);
    bit got;
    int t;
    din       = w;
    din_valid = 1'b1;
    got       = 1'b0;
    t         = 0;
    while (!got && t < 50) begin
      got = (m_ready === 1'b1);
      @(posedge clk);
      #1;
      t++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: word %0h not accepted within %0d cycles", w, t);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    clear_cap();

    // 1. Reset held with din_valid asserted.
    din       = 8'h55;
    din_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_x", 32'(m_x), 32'd0);
      check("rst_din_ready", 32'(m_ready), 32'd0);
      check("rst_word_count", 32'(m_wc), 32'd0);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("post_rst_ready", 32'(m_ready), 32'd1);
    check("post_rst_idle", 32'(m_idle), 32'd1);
    cycles(1);

    // 2. Single word A5 (both orders observed).
    clear_cap();
    offer(8'hA5);
    din_valid = 1'b0;
    cycles(10);
    check("t2_bits_msb", cap_m, 32'h0000_00A5);
    check("t2_nbits", 32'(ncap), 32'd8);
    check("t2_x_valid", 32'(m_xv), 32'd0);
    check("t2_idle", 32'(m_idle), 32'd1);
    check("t2_word_count", 32'(m_wc), 32'd1);

    // 3. LSB first: 0D goes out as 1,0,1,1,0,0,0,0.
    do_reset();
    clear_cap();
    offer(8'h0D);
    din_valid = 1'b0;
    cycles(10);
    check("t3_bits_lsb", cap_l, 32'h0000_00B0);
    check("t3_bits_msb", cap_m, 32'h0000_000D);

    // 4. Back-to-back with din_valid held high.
    do_reset();
    clear_cap();
    offer(8'hFF);
    offer(8'h00);
    offer(8'h3C);
    din_valid = 1'b0;
    cycles(30);
    check("t4_bits", cap_m, 32'h00FF_003C);
    check("t4_run", 32'(maxrun), 32'd24);
    check("t4_word_count", 32'(m_wc), 32'd3);

    // 5. Reset after the 4th bit of A5, then send 81.
    do_reset();
    clear_cap();
    offer(8'hA5);
    din_valid = 1'b0;
    cycles(3);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    offer(8'h81);
    din_valid = 1'b0;
    cycles(10);
    check("t5_bits", cap_m, 32'h0000_0A81);
    check("t5_nbits", 32'(ncap), 32'd12);
    check("t5_word_count", 32'(m_wc), 32'd1);

    // 6. word_count wrap from a preloaded value.
    do_reset();
    force dut_m.word_count = 16'hFFFE;
    force dut_l.word_count = 16'hFFFE;
    mcount = 16'hFFFE;
    #1;
    release dut_m.word_count;
    release dut_l.word_count;
    offer(8'h12);
    din_valid = 1'b0;
    cycles(10);
    check("t6_wc_ffff", 32'(m_wc), 32'h0000_FFFF);
    offer(8'h34);
    din_valid = 1'b0;
    cycles(10);
    check("t6_wc_wrap", 32'(m_wc), 32'h0000_0000);
    check("t6_wc_wrap_l", 32'(l_wc), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
